// File: rtl/cpu_stage_sequencer_pkg.sv
// rtl/cpu_stage_sequencer_pkg.sv - shared stage encoding and PC constants
package cpu_stage_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_FAULT     = 3'd6,
        ST_UNUSED    = 3'd7
    } stage_t;

    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cpu_stage_sequencer_mem_wait_timer.sv
// rtl/cpu_stage_sequencer_mem_wait_timer.sv - MEMORY-state wait counter with timeout flag
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [7:0] count;

    // Count enabled cycles; clear wins so a completed access restarts from zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    // Flags the cycle that would be the MEM_TIMEOUT-th waiting cycle
    assign timeout = en && (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_stage_sequencer.sv
// rtl/cpu_stage_sequencer.sv - multi-cycle FETCH..WRITEBACK stage controller with halt/step/fault
module cpu_stage_sequencer
    import cpu_stage_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        reg_wen_dec,
    input  logic        pc_sel,
    input  logic        illegal,
    input  logic [31:0] alu_out,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [2:0]  stage,
    output logic        ir_load,
    output logic        reg_we,
    output logic        ram_en,
    output logic        mem_wr,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    stage_t      state;
    stage_t      state_nxt;
    logic        step_flag;
    logic        step_flag_nxt;
    logic [31:0] pc_q;
    logic [31:0] instret_q;
    logic        in_mem;
    logic        in_wb;
    logic        timer_clr;
    logic        mem_timeout;

    assign in_mem    = (state == ST_MEMORY);
    assign in_wb     = (state == ST_WRITEBACK);
    assign timer_clr = !in_mem || mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (in_mem),
        .timeout(mem_timeout)
    );

    // State register and single-step flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            step_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_flag <= step_flag_nxt;
        end
    end

    // PC and retired count advance only in WRITEBACK; instret is rewritten every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else begin
            if (in_wb) begin
                pc_q <= pc_sel ? (alu_out & PC_ALIGN_MASK) : (pc_q + PC_INC);
            end
            instret_q <= instret_q + {31'd0, in_wb};
        end
    end

    // Next-state logic; halt is only honoured at the instruction boundary
    always_comb begin
        state_nxt     = state;
        step_flag_nxt = step_flag;
        case (state)
            ST_FETCH:   state_nxt = ST_DECODE;
            ST_DECODE:  state_nxt = illegal ? ST_FAULT : ST_EXECUTE;
            ST_EXECUTE: state_nxt = (is_load || is_store) ? ST_MEMORY : ST_WRITEBACK;
            ST_MEMORY: begin
                if (mem_ready) begin
                    state_nxt = ST_WRITEBACK;
                end else if (mem_timeout) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                state_nxt     = (halt_req || step_flag) ? ST_HALT : ST_FETCH;
                step_flag_nxt = 1'b0;
            end
            ST_HALT: begin
                if (step_req) begin
                    state_nxt     = ST_FETCH;
                    step_flag_nxt = 1'b1;
                end else if (!halt_req) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FAULT:   state_nxt = ST_FAULT;
            default:    state_nxt = ST_FAULT;
        endcase
    end

    // Moore strobes decoded from the state register, all held low during reset
    always_comb begin
        ir_load = 1'b0;
        reg_we  = 1'b0;
        ram_en  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH:     ir_load = 1'b1;
                ST_MEMORY: begin
                    ram_en = 1'b1;
                    mem_wr = is_store;
                end
                ST_WRITEBACK: reg_we = reg_wen_dec && !is_store;
                ST_HALT:      halted = 1'b1;
                ST_FAULT:     fault  = 1'b1;
                default:      ;
            endcase
        end
    end

    assign stage   = state;
    assign pc      = pc_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// tb/tb_cpu_stage_sequencer.sv - self-checking bench for cpu_stage_sequencer
module tb_cpu_stage_sequencer;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst, halt_req, step_req, is_load, is_store, reg_wen_dec, pc_sel, illegal, mem_ready;
    logic [31:0] alu_out;
    logic [31:0] pc, instret;
    logic [2:0]  stage;
    logic        ir_load, reg_we, ram_en, mem_wr, halted, fault;

    cpu_stage_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .step_req(step_req),
        .is_load(is_load), .is_store(is_store), .reg_wen_dec(reg_wen_dec),
        .pc_sel(pc_sel), .illegal(illegal), .alu_out(alu_out), .mem_ready(mem_ready),
        .pc(pc), .stage(stage), .ir_load(ir_load), .reg_we(reg_we), .ram_en(ram_en),
        .mem_wr(mem_wr), .halted(halted), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ld, st, rw, ps, il;
        logic [31:0] alu;
        int          wt;        // cycles before mem_ready; >= 255 means never
        int          halt_cyc;  // cycle index at which halt_req is raised, -1 none
        int          cyc;       // expected cycles until the next boundary
        logic [31:0] epc;
        int          ewe;
        int          eend;
    } instr_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instret = 32'h0;
    int          exp_seq[$];
    instr_t      tbl[8];
    instr_t      r;
    int          k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_vec(input int s, input bit rw, input bit st);
        logic [2:0] s3;
        s3 = 3'(s);
        return {s3, s == 0, (s == 4) && rw && !st, s == 3, (s == 3) && st, s == 5, s == 6};
    endfunction

    function automatic logic [8:0] act_vec();
        return {stage, ir_load, reg_we, ram_en, mem_wr, halted, fault};
    endfunction

    // Expected stage per cycle from the instruction's attributes
    function automatic void build_seq(input instr_t x);
        int n;
        exp_seq.delete();
        exp_seq.push_back(0);
        exp_seq.push_back(1);
        if (x.il) return;
        exp_seq.push_back(2);
        if (x.ld || x.st) begin
            n = (x.wt >= MEM_TIMEOUT) ? MEM_TIMEOUT : x.wt + 1;
            repeat (n) exp_seq.push_back(3);
            if (x.wt >= MEM_TIMEOUT) return;
        end
        exp_seq.push_back(4);
    endfunction

    task automatic run_instr(input instr_t x);
        int memcnt;
        int we_cnt;
        int s;
        memcnt = 0;
        we_cnt = 0;
        build_seq(x);
        is_load = x.ld; is_store = x.st; reg_wen_dec = x.rw; pc_sel = x.ps;
        illegal = x.il; alu_out = x.alu;
        for (int c = 0; c < x.cyc; c++) begin
            s = (c < exp_seq.size()) ? exp_seq[c] : 7;
            if (c == x.halt_cyc) halt_req = 1'b1;
            if (s == 3) begin
                memcnt++;
                mem_ready = (memcnt == x.wt + 1);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            chk("cycle_outputs", act_vec(), exp_vec(s, x.rw, x.st));
            chk("cycle_pc", pc, m_pc);
            chk("cycle_instret", instret, m_instret);
            if (reg_we) we_cnt++;
            @(posedge clk); #1;
        end
        if (x.eend != 6) begin
            m_pc = x.ps ? (x.alu & 32'hFFFF_FFFC) : m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
        end
        mem_ready = 1'b0;
        #1;
        chk("end_stage", stage, x.eend);
        chk("end_pc", pc, x.epc);
        chk("we_pulses", we_cnt, x.ewe);
        chk("end_instret", instret, m_instret);
    endtask

    task automatic hold_state(input int n, input int s);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'b1; is_store = 1'b1; reg_wen_dec = 1'b1;
            if (s == 6) step_req = 1'b1;
            #1;
            chk("hold_outputs", act_vec(), exp_vec(s, 1'b1, 1'b1));
            chk("hold_pc", pc, m_pc);
            chk("hold_instret", instret, m_instret);
            @(posedge clk); #1;
        end
        step_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; halt_req = 1'b0; step_req = 1'b0;
        is_load = 1'b0; is_store = 1'b1; reg_wen_dec = 1'b1; illegal = 1'b1; mem_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_strobes", {ir_load, reg_we, ram_en, mem_wr, halted, fault}, 6'b0);
        rst = 1'b0; illegal = 1'b0; mem_ready = 1'b0;
        #1;
        m_pc = 32'h0; m_instret = 32'h0;
        chk("rst_stage", stage, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instret", instret, 32'h0);
    endtask

    initial begin
        //              ld    st    rw    ps    il    alu            wt  hc  cyc epc            we end
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         0, -1, 4,  32'h4,         1, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         3, -1, 8,  32'h8,         1, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h103,       0, -1, 4,  32'h100,       0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         0, -1, 5,  32'h104,       0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 0, -1, 4,  32'hFFFF_FFFC, 1, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         0, -1, 4,  32'h0,         1, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        14, -1, 19, 32'h4,         1, 0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         0,  1, 4,  32'h8,         1, 5};

        alu_out = 32'h0; pc_sel = 1'b0;
        do_reset(2);

        for (int i = 0; i < 8; i++) run_instr(tbl[i]);

        // Halted with halt_req held: pc frozen
        hold_state(2, 5);

        // Preload instret to all-ones so the next retirement wraps
        force dut.instret_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        #1;
        chk("instret_preload", instret, 32'hFFFF_FFFF);

        // One-cycle step with halt_req still high
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, -1, 4, 32'hC, 1, 5};
        run_instr(r);
        chk("instret_wrap", instret, 32'h0);

        // Step with halt_req dropped in the same cycle: step flag still returns to HALT
        halt_req = 1'b0; step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, -1, 4, 32'h10, 1, 5};
        run_instr(r);

        // Neither request: resume fetching
        @(posedge clk); #1;
        chk("resume_stage", stage, 0);

        // Illegal opcode faults from DECODE with no strobes
        r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 0, -1, 2, 32'h10, 0, 6};
        run_instr(r);
        hold_state(3, 6);
        do_reset(1);

        // Reset in the middle of a MEMORY wait
        is_load = 1'b1; is_store = 1'b0; reg_wen_dec = 1'b1; pc_sel = 1'b0; mem_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("midmem_stage", stage, 3);
        chk("midmem_ram_en", ram_en, 1'b1);
        rst = 1'b1; #1;
        chk("midmem_rst_strobes", {ram_en, reg_we}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("midmem_after_stage", stage, 0);
        chk("midmem_after_pc", pc, 32'h0);

        // Randomised instruction stream against the model
        for (int i = 0; i < 25; i++) begin
            k = $urandom_range(0, 2);
            r.ld = (k == 1); r.st = (k == 2);
            r.rw = 1'($urandom_range(0, 1));
            r.ps = 1'($urandom_range(0, 1));
            r.il = 1'b0;
            r.alu = $urandom;
            r.wt = $urandom_range(0, MEM_TIMEOUT - 1);
            r.halt_cyc = -1;
            r.eend = 0;
            r.epc = r.ps ? (r.alu & 32'hFFFF_FFFC) : m_pc + 32'd4;
            r.ewe = (r.rw && !r.st) ? 1 : 0;
            r.cyc = (k == 0) ? 4 : 5 + r.wt;
            run_instr(r);
        end

        // Store that never completes: FAULT after MEM_TIMEOUT MEMORY cycles
        r = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 255, -1, 3 + MEM_TIMEOUT, m_pc, 0, 6};
        run_instr(r);
        hold_state(2, 6);
        do_reset(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
